// File: rtl/uart_resp_trans.sv
// uart_resp_trans
// ---------------
// Serial UART transmitter that returns responses from the chip to host
// software. Three packet types are framed (8N1, LSB first):
//   ACK    = {ACK_BYTE}
//   RESEND = {NAK_BYTE}
//   RESULT = {RES_BYTE, label, RES_BYTE ^ label}, sent back to back
// Requests are latched as pending flags and arbitrated only between packets
// (RESEND > ACK > RESULT). Host flow control (USB_RTS) is honoured only at
// byte boundaries; a byte that has started always completes.
//
// Ports
//   uart_sampling_clk  in   sole clock, OVERSAMPLE cycles per serial bit
//   rst                in   asynchronous, active-low reset
//   ack                in   single-cycle pulse: queue an ACK packet
//   resend             in   single-cycle pulse: queue a RESEND packet
//   result_valid       in   result_label is valid
//   result_label[7:0]  in   classified digit label
//   result_ready       out  result buffer empty, a result can be accepted
//   USB_RTS            in   high = host can receive
//   USB_TX             out  serial line, idles high
//   busy               out  a byte is being shifted or a packet is in progress
module uart_resp_trans #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter logic [7:0]  ACK_BYTE   = 8'h06,
  parameter logic [7:0]  NAK_BYTE   = 8'h15,
  parameter logic [7:0]  RES_BYTE   = 8'h52
) (
  input  logic       uart_sampling_clk,
  input  logic       rst,
  input  logic       ack,
  input  logic       resend,
  input  logic       result_valid,
  input  logic [7:0] result_label,
  output logic       result_ready,
  input  logic       USB_RTS,
  output logic       USB_TX,
  output logic       busy
);

  localparam logic [7:0] OS_LAST = 8'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  // RESULT checksum: plain 8-bit XOR, no carry.
  function automatic logic [7:0] checksum(input logic [7:0] hdr, input logic [7:0] lbl);
    return hdr ^ lbl;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;            // cycle within the current bit
  logic [2:0]  bit_idx_q, bit_idx_d;    // data bit index 0..7
  logic [7:0]  shift_q, shift_d;        // bit 0 is the data bit on the line
  logic [1:0]  bytes_left_q, bytes_left_d;
  logic        pkt_res_q, pkt_res_d;    // current packet is a RESULT
  logic [7:0]  label_q, label_d;
  logic        ack_p_q, ack_p_d;
  logic        nak_p_q, nak_p_d;
  logic        res_p_q, res_p_d;
  logic        ready_q, ready_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;

  logic        cnt_end_s;
  logic        pending_s;
  logic        start_pkt_s;
  logic        accept_s;
  logic        pkt_done_s;
  logic        sel_nak_s;
  logic        sel_ack_s;
  logic        sel_res_s;
  logic [7:0]  next_byte_s;

  assign cnt_end_s   = (cnt_q == OS_LAST);
  assign pending_s   = ack_p_q | nak_p_q | res_p_q;
  assign start_pkt_s = (state_q == S_IDLE) && pending_s && USB_RTS;
  assign accept_s    = result_valid && ready_q;
  assign pkt_done_s  = (state_q == S_STOP) && cnt_end_s && (bytes_left_q == 2'd0);

  // Fixed priority between pending packets.
  assign sel_nak_s = nak_p_q;
  assign sel_ack_s = !nak_p_q && ack_p_q;
  assign sel_res_s = !nak_p_q && !ack_p_q && res_p_q;

  // Only RESULT packets have follow-on bytes: label, then checksum.
  assign next_byte_s = (bytes_left_q == 2'd2) ? label_q : checksum(RES_BYTE, label_q);

  assign USB_TX       = tx_q;
  assign busy         = busy_q;
  assign result_ready = ready_q;

  // Frame state register.
  always_ff @(posedge uart_sampling_clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_pkt_s) state_d = S_START;
        else             state_d = S_IDLE;
      end
      S_START: begin
        if (cnt_end_s) state_d = S_DATA;
        else           state_d = S_START;
      end
      S_DATA: begin
        if (cnt_end_s && (bit_idx_q == 3'd7)) state_d = S_STOP;
        else                                  state_d = S_DATA;
      end
      S_STOP: begin
        // With bytes remaining and RTS low, stay in STOP holding the line high.
        if (pkt_done_s)                  state_d = S_IDLE;
        else if (cnt_end_s && USB_RTS)   state_d = S_START;
        else                             state_d = S_STOP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Serialiser datapath and next values of the registered line outputs.
  always_comb begin
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    bytes_left_d = bytes_left_q;
    pkt_res_d    = pkt_res_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    case (state_q)
      S_IDLE: begin
        cnt_d     = 8'd0;
        bit_idx_d = 3'd0;
        if (start_pkt_s) begin
          tx_d   = 1'b0;
          busy_d = 1'b1;
          if (sel_nak_s) begin
            shift_d      = NAK_BYTE;
            bytes_left_d = 2'd0;
            pkt_res_d    = 1'b0;
          end else if (sel_ack_s) begin
            shift_d      = ACK_BYTE;
            bytes_left_d = 2'd0;
            pkt_res_d    = 1'b0;
          end else begin
            shift_d      = RES_BYTE;
            bytes_left_d = 2'd2;
            pkt_res_d    = 1'b1;
          end
        end else begin
          tx_d   = 1'b1;
          busy_d = 1'b0;
        end
      end
      S_START: begin
        if (cnt_end_s) begin
          cnt_d     = 8'd0;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DATA: begin
        if (cnt_end_s) begin
          cnt_d = 8'd0;
          if (bit_idx_q == 3'd7) begin
            tx_d = 1'b1;
          end else begin
            tx_d      = shift_q[1];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_STOP: begin
        if (pkt_done_s) begin
          cnt_d     = 8'd0;
          tx_d      = 1'b1;
          busy_d    = 1'b0;
          pkt_res_d = 1'b0;
        end else if (cnt_end_s) begin
          if (USB_RTS) begin
            cnt_d        = 8'd0;
            tx_d         = 1'b0;
            shift_d      = next_byte_s;
            bytes_left_d = bytes_left_q - 2'd1;
          end else begin
            // Stall: counter parked at the end of the stop bit.
            tx_d = 1'b1;
          end
        end else begin
          tx_d  = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        cnt_d  = 8'd0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  // Pending flags, result buffer and handshake.
  always_comb begin
    // A pulse arriving on the edge its packet is loaded merges into that packet.
    if (start_pkt_s && sel_nak_s) nak_p_d = 1'b0;
    else                          nak_p_d = nak_p_q | resend;

    if (start_pkt_s && sel_ack_s) ack_p_d = 1'b0;
    else                          ack_p_d = ack_p_q | ack;

    if (start_pkt_s && sel_res_s) res_p_d = 1'b0;
    else                          res_p_d = res_p_q | accept_s;

    if (accept_s) label_d = result_label;
    else          label_d = label_q;

    // The buffer stays full until the RESULT packet has fully left the line.
    if (accept_s)                     ready_d = 1'b0;
    else if (pkt_done_s && pkt_res_q) ready_d = 1'b1;
    else                              ready_d = ready_q;
  end

  // Datapath, flag and output registers.
  always_ff @(posedge uart_sampling_clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= 8'd0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'd0;
      bytes_left_q <= 2'd0;
      pkt_res_q    <= 1'b0;
      label_q      <= 8'd0;
      ack_p_q      <= 1'b0;
      nak_p_q      <= 1'b0;
      res_p_q      <= 1'b0;
      ready_q      <= 1'b1;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      bytes_left_q <= bytes_left_d;
      pkt_res_q    <= pkt_res_d;
      label_q      <= label_d;
      ack_p_q      <= ack_p_d;
      nak_p_q      <= nak_p_d;
      res_p_q      <= res_p_d;
      ready_q      <= ready_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_resp_trans.sv
module tb_uart_resp_trans;

  localparam int OS = 4;

  logic       clk;
  logic       rst;
  logic       ack;
  logic       resend;
  logic       result_valid;
  logic [7:0] result_label;
  logic       result_ready;
  logic       USB_RTS;
  logic       USB_TX;
  logic       busy;

  int n_vec;
  int n_err;

  uart_resp_trans #(
    .OVERSAMPLE(OS),
    .ACK_BYTE  (8'h06),
    .NAK_BYTE  (8'h15),
    .RES_BYTE  (8'h52)
  ) dut (
    .uart_sampling_clk(clk),
    .rst              (rst),
    .ack              (ack),
    .resend           (resend),
    .result_valid     (result_valid),
    .result_label     (result_label),
    .result_ready     (result_ready),
    .USB_RTS          (USB_RTS),
    .USB_TX           (USB_TX),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       ack;
    logic       resend;
    logic       valid;
    logic [7:0] label;
    logic       rts;
    logic       exp_tx;
    logic       exp_busy;
    logic       exp_ready;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic act, input logic exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %b, want %b", nm, act, exp_v);
    end
  endtask

  task automatic chk_line(input string nm, input logic e_tx, input logic e_busy, input logic e_rdy);
    chk({nm, " tx"}, USB_TX, e_tx);
    chk({nm, " busy"}, busy, e_busy);
    chk({nm, " ready"}, result_ready, e_rdy);
  endtask

  // Called at the negedge showing the first start-bit cycle; checks a full
  // 10*OS-cycle frame and leaves off at the negedge right after the stop bit.
  task automatic expect_byte(input logic [7:0] b, input string nm, input logic exp_rdy,
                             input int ack_at, input int rts_low_at);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int k = 0; k < 10 * OS; k++) begin
      ack = (k == ack_at) ? 1'b1 : 1'b0;
      if (k == rts_low_at) USB_RTS = 1'b0;
      chk_line($sformatf("%s c%0d", nm, k), frame[k / OS], 1'b1, exp_rdy);
      @(negedge clk);
    end
    ack = 1'b0;
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    rst          = 1'b0;
    ack          = 1'b0;
    resend       = 1'b0;
    result_valid = 1'b0;
    result_label = 8'h00;
    USB_RTS      = 1'b1;

    //          rst   ack   rsnd  vld   label  rts   tx    busy  rdy
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset, idle, then an ACK held off by RTS low and released by RTS high.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      rst          = vecs[i].rst_n;
      ack          = vecs[i].ack;
      resend       = vecs[i].resend;
      result_valid = vecs[i].valid;
      result_label = vecs[i].label;
      USB_RTS      = vecs[i].rts;
      @(negedge clk);
      chk_line($sformatf("vec%0d", i), vecs[i].exp_tx, vecs[i].exp_busy, vecs[i].exp_ready);
    end
    ack = 1'b0;
    expect_byte(8'h06, "ack", 1'b1, -1, -1);
    chk_line("ack end", 1'b1, 1'b0, 1'b1);

    // ACK pulse from idle with RTS high: line low after the following edge.
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk_line("ack2 lat", 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    expect_byte(8'h06, "ack2", 1'b1, -1, -1);
    chk_line("ack2 end", 1'b1, 1'b0, 1'b1);

    // ack + resend together, plus an ack repeat mid-frame that must merge.
    ack    = 1'b1;
    resend = 1'b1;
    @(negedge clk);
    ack    = 1'b0;
    resend = 1'b0;
    chk_line("pair lat", 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    expect_byte(8'h15, "nak", 1'b1, 8, -1);
    chk_line("nak gap", 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    expect_byte(8'h06, "ack3", 1'b1, -1, -1);
    for (int i = 0; i < 20; i++) begin
      chk_line($sformatf("merge idle%0d", i), 1'b1, 1'b0, 1'b1);
      @(negedge clk);
    end

    // RESULT 0x07 with RTS high: 0x52, 0x07, 0x55 back to back.
    result_valid = 1'b1;
    result_label = 8'h07;
    @(negedge clk);
    result_valid = 1'b0;
    chk_line("res1 acc", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    expect_byte(8'h52, "res1 b0", 1'b0, -1, -1);
    expect_byte(8'h07, "res1 b1", 1'b0, -1, -1);
    expect_byte(8'h55, "res1 b2", 1'b0, -1, -1);
    chk_line("res1 end", 1'b1, 1'b0, 1'b1);
    @(negedge clk);

    // RESULT 0x3C with RTS dropped mid second byte; stall 50 cycles in STOP.
    result_valid = 1'b1;
    result_label = 8'h3C;
    @(negedge clk);
    result_valid = 1'b0;
    @(negedge clk);
    expect_byte(8'h52, "res2 b0", 1'b0, -1, -1);
    expect_byte(8'h3C, "res2 b1", 1'b0, -1, 20);
    for (int i = 0; i < 50; i++) begin
      chk_line($sformatf("stall%0d", i), 1'b1, 1'b1, 1'b0);
      if (i == 49) USB_RTS = 1'b1;
      @(negedge clk);
    end
    expect_byte(8'h6E, "res2 b2", 1'b0, -1, -1);
    chk_line("res2 end", 1'b1, 1'b0, 1'b1);
    @(negedge clk);

    // Reset in the DATA phase of 0x52 with an ACK also pending.
    result_valid = 1'b1;
    result_label = 8'hA5;
    @(negedge clk);
    result_valid = 1'b0;
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    repeat (4) @(negedge clk);
    chk_line("pre rst", 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    chk_line("async rst", 1'b1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk_line($sformatf("post rst%0d", i), 1'b1, 1'b0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
